if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction fetch stage that sits directly upstream of the instruction RAM and feeds the decode stage. It owns the program counter and issues one read per cycle to the synchronous-read instruction RAM, which has 1-cycle latency. Returned words are captured with their PC in a small FIFO and handed to decode over a valid/ready handshake. A redirect input (branch/jump/trap) flushes queued and in-flight fetches and restarts at a new PC.

## Interface
- DATA_WIDTH, 32, instruction width
- ADDR_WIDTH, 32, PC / byte-address width
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- FIFO_DEPTH, 3, instruction buffer entries (minimum 2; 3 gives full throughput)

- clk  in  1  single clock; all state changes on posedge
- rst  in  1  reset, synchronous, active-high
- o_imem_en  out  1  read request this cycle
- o_imem_addr  out  ADDR_WIDTH  byte address of the request (= PC)
- i_imem_rdata  in  DATA_WIDTH  read data, valid the cycle after o_imem_en
- i_redirect_valid  in  1  redirect request
- i_redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] ignored (treated as 0)
- o_inst_valid  out  1  instruction available to decode
- o_inst  out  DATA_WIDTH  FIFO head instruction
- o_inst_pc  out  ADDR_WIDTH  PC of o_inst
- i_inst_ready  in  1  decode accepts head when o_inst_valid & i_inst_ready

## Operation
- State: pc, inflight (1 bit, request issued last cycle), FIFO of {inst, pc}, count.
- Issue: o_imem_en = !rst & !i_redirect_valid & (count + inflight < FIFO_DEPTH). o_imem_addr = pc always.
- On issue: pc <= pc + 4, mod 2^ADDR_WIDTH (0xFFFF_FFFC wraps to 0x0); inflight <= 1 and the issued PC is saved. Otherwise inflight <= 0.
- Capture: when inflight = 1 and there is no redirect this cycle, push {i_imem_rdata, saved PC}.
- Pop: o_inst_valid & i_inst_ready removes the head. Push and pop in the same cycle are allowed, and count is unchanged.
- The issue rule guarantees no overflow. A push when full is a design error; the bench asserts that it never occurs.
- o_inst_valid = (count != 0) & !i_redirect_valid. o_inst and o_inst_pc are the head entry; their value is don't-care when not valid.
- Redirect (i_redirect_valid = 1), which has priority over everything:
  - no issue this cycle;
  - the FIFO is cleared;
  - any response arriving this cycle is dropped;
  - inflight <= 0;
  - pc <= {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  - a handshake in this cycle is not a transfer.
- Back-to-back redirects: the last one wins. Each redirect cycle blocks issue.
- Reset: at a posedge with rst = 1, pc <= RESET_PC, count <= 0, inflight <= 0. Any response that arrives after reset is discarded.

## Timing
- Outputs during and after reset: o_imem_en = 0 while rst = 1, o_inst_valid = 0, o_imem_addr = RESET_PC.
- Cycle 0 is the first cycle with rst = 0. In cycle 0, o_imem_en = 1 and addr = RESET_PC.
- Issue-to-output latency is 2 cycles: issue in cycle n, data in cycle n+1, o_inst_valid in cycle n+2.
- With i_inst_ready held at 1, throughput is 1 instruction per cycle in steady state (count = 1, inflight = 1).
- Backpressure: with ready at 0, issue stops once count + inflight = FIFO_DEPTH. The PC does not skip or repeat.
- After ready returns, o_imem_en reasserts in the same cycle the pop frees a slot is NOT required. It reasserts the cycle after the pop (registered count).
- Redirect in cycle r: cycle r+1 issues the new PC, and cycle r+3 presents the first new-path instruction. No stale instruction is visible after cycle r.
- Combinational paths are limited to two:
  - i_redirect_valid to o_imem_en and o_inst_valid;
  - rst to o_imem_en.
- i_inst_ready does not reach o_imem_en.

## Test plan
- Reset and stream: bench RAM returns mem[a] = 0xA500_0000 | a, and ready is held at 1. Required: o_inst_pc = 0x0, 0x4, 0x8, … appears from cycle 2, one per cycle, with o_inst = 0xA500_0000 | pc.
- Backpressure: ready = 0 for 6 cycles mid-stream, then 1. Required: o_imem_en falls within 2 cycles and count stays ≤ 3. After release, PCs continue with no gap or duplicate.
- Redirect with in-flight: pulse redirect to 0x0000_1002 while streaming. Required: the in-flight word is dropped and the FIFO empties. The next issue is 0x1000, and the next accepted o_inst_pc is 0x1000, followed by 0x1004.
- Redirect with simultaneous handshake: redirect to 0x200 while o_inst_valid & ready. Required: no transfer is recorded, and the first accepted PC is 0x200.
- Wrap-around: RESET_PC = 0xFFFF_FFF8. Required: fetched PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset mid-operation: assert rst for 2 cycles with the FIFO full and a request in flight. Required: o_inst_valid is 0 from the next edge, and restart at RESET_PC with no old instruction ever delivered.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to a
// 1-cycle-latency instruction RAM and buffers returned words for decode.
module if_fetch_unit #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
    parameter int unsigned            FIFO_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_imem_en,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    input  logic                  i_inst_ready
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    entry_t                fifo_q [FIFO_DEPTH];
    entry_t                fifo_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  inflight_q, inflight_d;
    ptr_t                  rd_ptr_q, rd_ptr_d;
    ptr_t                  wr_ptr_q, wr_ptr_d;
    cnt_t                  count_q, count_d;

    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [CW:0]           occupancy;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Slots are reserved for the in-flight word, so issue never overflows.
    always_comb begin
        occupancy    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue        = !rst && !i_redirect_valid && (occupancy < DEPTH_C);
        o_inst_valid = (count_q != '0) && !i_redirect_valid;
        pop          = o_inst_valid && i_inst_ready;
        push         = inflight_q && !i_redirect_valid;
    end

    assign o_imem_en   = issue;
    assign o_imem_addr = pc_q;
    assign o_inst      = fifo_q[rd_ptr_q].inst;
    assign o_inst_pc   = fifo_q[rd_ptr_q].pc;

    always_comb begin
        fifo_d     = fifo_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (i_redirect_valid) begin
            pc_d     = i_redirect_pc & ~ADDR_WIDTH'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                pc_d       = pc_q + ADDR_WIDTH'(4);
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
            if (push) begin
                fifo_d[wr_ptr_q].inst = i_imem_rdata;
                fifo_d[wr_ptr_q].pc   = req_pc_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule
